// File: rtl/wb_arbiter.sv
// Write-back arbiter: three completion sources share two registered write-back ports.
// WB_WAW_GUARD_EN: define to let only one of two same-destination requests through per cycle.
module wb_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c0_valid,
  input  logic [4:0]  c0_dest,
  input  logic [31:0] c0_data,
  output logic        c0_ready,
  input  logic        c1_valid,
  input  logic [4:0]  c1_dest,
  input  logic [31:0] c1_data,
  output logic        c1_ready,
  input  logic        c2_valid,
  input  logic [4:0]  c2_dest,
  input  logic [31:0] c2_data,
  output logic        c2_ready,
  output logic        wb_valid1,
  output logic [4:0]  wb_dest1,
  output logic [31:0] wb_data1,
  output logic        wb_valid2,
  output logic [4:0]  wb_dest2,
  output logic [31:0] wb_data2
);

  localparam int DATA_W = 32;
  localparam int DEST_W = 5;

  logic [1:0]        rr_ptr;
  logic [1:0]        ptr_eff;
  logic [2:0]        valid_v;
  logic [2:0]        ready_v;
  logic [DEST_W-1:0] dest_v [3];
  logic [DATA_W-1:0] data_v [3];

  logic       gnt1;
  logic       gnt2;
  logic [1:0] sel1;
  logic [1:0] sel2;
  logic       deny_any;
  logic [1:0] deny_idx;
  logic [1:0] src;
  logic       waw_hit;

  function automatic logic [1:0] wrap_add(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  assign valid_v   = {c2_valid, c1_valid, c0_valid};
  assign dest_v[0] = c0_dest;
  assign dest_v[1] = c1_dest;
  assign dest_v[2] = c2_dest;
  assign data_v[0] = c0_data;
  assign data_v[1] = c1_data;
  assign data_v[2] = c2_data;

  // An out-of-range pointer is folded back to source 0.
  assign ptr_eff = (rr_ptr == 2'd3) ? 2'd0 : rr_ptr;

  // Grant decision: walks sources in rotating priority; data never enters this path.
  always_comb begin
    ready_v  = '0;
    gnt1     = 1'b0;
    gnt2     = 1'b0;
    sel1     = 2'd0;
    sel2     = 2'd0;
    deny_any = 1'b0;
    deny_idx = 2'd0;
    src      = 2'd0;
    waw_hit  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      src = wrap_add(ptr_eff, 2'(i));
`ifdef WB_WAW_GUARD_EN
      waw_hit = gnt1 && (dest_v[src] == dest_v[sel1]);
`else
      waw_hit = 1'b0;
`endif
      if (valid_v[src]) begin
        if (dest_v[src] == '0) begin
          ready_v[src] = 1'b1;
        end else if (!gnt1) begin
          gnt1         = 1'b1;
          sel1         = src;
          ready_v[src] = 1'b1;
        end else if (!gnt2 && !waw_hit) begin
          gnt2         = 1'b1;
          sel2         = src;
          ready_v[src] = 1'b1;
        end else if (!deny_any) begin
          deny_any = 1'b1;
          deny_idx = src;
        end
      end
    end
  end

  // Grants are withheld while reset is asserted.
  assign c0_ready = ready_v[0] & rst_n;
  assign c1_ready = ready_v[1] & rst_n;
  assign c2_ready = ready_v[2] & rst_n;

  // Stage boundary: grants become registered write-back one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= 2'd0;
      wb_valid1 <= 1'b0;
      wb_valid2 <= 1'b0;
      wb_dest1  <= '0;
      wb_dest2  <= '0;
      wb_data1  <= '0;
      wb_data2  <= '0;
    end else begin
      wb_valid1 <= gnt1;
      wb_valid2 <= gnt2;
      if (gnt1) begin
        wb_dest1 <= dest_v[sel1];
        wb_data1 <= data_v[sel1];
      end
      if (gnt2) begin
        wb_dest2 <= dest_v[sel2];
        wb_data2 <= data_v[sel2];
      end
      rr_ptr <= deny_any ? deny_idx : ptr_eff;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; expectations follow WB_WAW_GUARD_EN when defined.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c0_valid, c1_valid, c2_valid;
  logic [4:0]  c0_dest, c1_dest, c2_dest;
  logic [31:0] c0_data, c1_data, c2_data;
  logic        c0_ready, c1_ready, c2_ready;
  logic        wb_valid1, wb_valid2;
  logic [4:0]  wb_dest1, wb_dest2;
  logic [31:0] wb_data1, wb_data2;

  int checks = 0;
  int errors = 0;

  wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .c0_valid(c0_valid), .c0_dest(c0_dest), .c0_data(c0_data), .c0_ready(c0_ready),
    .c1_valid(c1_valid), .c1_dest(c1_dest), .c1_data(c1_data), .c1_ready(c1_ready),
    .c2_valid(c2_valid), .c2_dest(c2_dest), .c2_data(c2_data), .c2_ready(c2_ready),
    .wb_valid1(wb_valid1), .wb_dest1(wb_dest1), .wb_data1(wb_data1),
    .wb_valid2(wb_valid2), .wb_dest2(wb_dest2), .wb_data2(wb_data2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    c0_valid = 0; c1_valid = 0; c2_valid = 0;
    c0_dest = 0; c1_dest = 0; c2_dest = 0;
    c0_data = 0; c1_data = 0; c2_data = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    c0_valid = 1; c0_dest = 5'd3; c0_data = 32'h1234;
    step(); step();
    checks++;
    if ({c2_ready, c1_ready, c0_ready} !== 3'b000) begin
      errors++; $display("FAIL reset_ready: got %b want 000", {c2_ready, c1_ready, c0_ready});
    end
    checks++;
    if ({wb_valid1, wb_valid2} !== 2'b00) begin
      errors++; $display("FAIL reset_valid: got %b want 00", {wb_valid1, wb_valid2});
    end
    checks++;
    if ({wb_dest1, wb_dest2, wb_data1, wb_data2} !== 74'd0) begin
      errors++; $display("FAIL reset_regs: d1=%0d d2=%0d w1=%h w2=%h want all 0",
                         wb_dest1, wb_dest2, wb_data1, wb_data2);
    end
    checks++;
    if (dut.rr_ptr !== 2'd0) begin
      errors++; $display("FAIL reset_ptr: got %0d want 0", dut.rr_ptr);
    end
    clear_inputs();
    rst_n = 1;
    step();
  endtask

  task automatic test_single();
    c2_valid = 1; c2_dest = 5'd7; c2_data = 32'hDEADBEEF;
    #1;
    checks++;
    if ({c2_ready, c1_ready, c0_ready} !== 3'b100) begin
      errors++; $display("FAIL single_ready: got %b want 100", {c2_ready, c1_ready, c0_ready});
    end
    step();
    clear_inputs();
    checks++;
    if ({wb_valid1, wb_dest1, wb_data1, wb_valid2} !== {1'b1, 5'd7, 32'hDEADBEEF, 1'b0}) begin
      errors++; $display("FAIL single_wb: v1=%b d1=%0d w1=%h v2=%b want 1 7 deadbeef 0",
                         wb_valid1, wb_dest1, wb_data1, wb_valid2);
    end
    step();
    checks++;
    if ({wb_valid1, wb_dest1, wb_data1} !== {1'b0, 5'd7, 32'hDEADBEEF}) begin
      errors++; $display("FAIL single_hold: v1=%b d1=%0d w1=%h want 0 7 deadbeef",
                         wb_valid1, wb_dest1, wb_data1);
    end
  endtask

  task automatic test_contention();
    c0_valid = 1; c0_dest = 5'd3; c0_data = 32'hA0;
    c1_valid = 1; c1_dest = 5'd4; c1_data = 32'hA1;
    c2_valid = 1; c2_dest = 5'd5; c2_data = 32'hA2;
    #1;
    checks++;
    if ({c2_ready, c1_ready, c0_ready} !== 3'b011) begin
      errors++; $display("FAIL cont_ready: got %b want 011", {c2_ready, c1_ready, c0_ready});
    end
    step();
    c0_valid = 0; c1_valid = 0;
    checks++;
    if ({wb_valid1, wb_dest1, wb_data1, wb_valid2, wb_dest2, wb_data2} !==
        {1'b1, 5'd3, 32'hA0, 1'b1, 5'd4, 32'hA1}) begin
      errors++; $display("FAIL cont_ports: v1=%b d1=%0d v2=%b d2=%0d want 1 3 1 4",
                         wb_valid1, wb_dest1, wb_valid2, wb_dest2);
    end
    checks++;
    if (dut.rr_ptr !== 2'd2) begin
      errors++; $display("FAIL cont_ptr: got %0d want 2", dut.rr_ptr);
    end
    #1;
    checks++;
    if ({c2_ready, c1_ready, c0_ready} !== 3'b100) begin
      errors++; $display("FAIL cont_retry_ready: got %b want 100", {c2_ready, c1_ready, c0_ready});
    end
    step();
    clear_inputs();
    checks++;
    if ({wb_valid1, wb_dest1, wb_data1, wb_valid2} !== {1'b1, 5'd5, 32'hA2, 1'b0}) begin
      errors++; $display("FAIL cont_retry_wb: v1=%b d1=%0d w1=%h v2=%b want 1 5 a2 0",
                         wb_valid1, wb_dest1, wb_data1, wb_valid2);
    end
    step();
  endtask

  // Pointer is 2 here: order is c2, c0, c1.
  task automatic test_zero_dest();
    c0_valid = 1; c0_dest = 5'd0; c0_data = 32'h55;
    c1_valid = 1; c1_dest = 5'd9; c1_data = 32'h99;
    #1;
    checks++;
    if ({c2_ready, c1_ready, c0_ready} !== 3'b011) begin
      errors++; $display("FAIL zero_ready: got %b want 011", {c2_ready, c1_ready, c0_ready});
    end
    step();
    clear_inputs();
    checks++;
    if ({wb_valid1, wb_dest1, wb_data1, wb_valid2} !== {1'b1, 5'd9, 32'h99, 1'b0}) begin
      errors++; $display("FAIL zero_wb: v1=%b d1=%0d w1=%h v2=%b want 1 9 99 0",
                         wb_valid1, wb_dest1, wb_data1, wb_valid2);
    end
    checks++;
    if (dut.rr_ptr !== 2'd2) begin
      errors++; $display("FAIL zero_ptr: got %0d want 2", dut.rr_ptr);
    end
    step();
  endtask

  task automatic test_same_dest();
    c0_valid = 1; c0_dest = 5'd12; c0_data = 32'hC0;
    c1_valid = 1; c1_dest = 5'd12; c1_data = 32'hC1;
    #1;
`ifdef WB_WAW_GUARD_EN
    checks++;
    if ({c2_ready, c1_ready, c0_ready} !== 3'b001) begin
      errors++; $display("FAIL waw_ready: got %b want 001", {c2_ready, c1_ready, c0_ready});
    end
    step();
    c0_valid = 0;
    checks++;
    if ({wb_valid1, wb_dest1, wb_data1, wb_valid2} !== {1'b1, 5'd12, 32'hC0, 1'b0}) begin
      errors++; $display("FAIL waw_first: v1=%b d1=%0d w1=%h v2=%b want 1 12 c0 0",
                         wb_valid1, wb_dest1, wb_data1, wb_valid2);
    end
    checks++;
    if (dut.rr_ptr !== 2'd1) begin
      errors++; $display("FAIL waw_ptr: got %0d want 1", dut.rr_ptr);
    end
    step();
    clear_inputs();
    checks++;
    if ({wb_valid1, wb_dest1, wb_data1, wb_valid2} !== {1'b1, 5'd12, 32'hC1, 1'b0}) begin
      errors++; $display("FAIL waw_second: v1=%b d1=%0d w1=%h v2=%b want 1 12 c1 0",
                         wb_valid1, wb_dest1, wb_data1, wb_valid2);
    end
`else
    checks++;
    if ({c2_ready, c1_ready, c0_ready} !== 3'b011) begin
      errors++; $display("FAIL waw_ready: got %b want 011", {c2_ready, c1_ready, c0_ready});
    end
    step();
    clear_inputs();
    checks++;
    if ({wb_valid1, wb_dest1, wb_data1, wb_valid2, wb_dest2, wb_data2} !==
        {1'b1, 5'd12, 32'hC0, 1'b1, 5'd12, 32'hC1}) begin
      errors++; $display("FAIL waw_both: v1=%b d1=%0d w1=%h v2=%b d2=%0d w2=%h want 1 12 c0 1 12 c1",
                         wb_valid1, wb_dest1, wb_data1, wb_valid2, wb_dest2, wb_data2);
    end
    checks++;
    if (dut.rr_ptr !== 2'd2) begin
      errors++; $display("FAIL waw_ptr: got %0d want 2", dut.rr_ptr);
    end
`endif
    step();
  endtask

  task automatic test_reset_mid();
    c0_valid = 1; c0_dest = 5'd1; c0_data = 32'hF0;
    c1_valid = 1; c1_dest = 5'd2; c1_data = 32'hF1;
    c2_valid = 1; c2_dest = 5'd3; c2_data = 32'hF2;
    step();
    checks++;
    if (wb_valid1 !== 1'b1) begin
      errors++; $display("FAIL mid_pre: wb_valid1=%b want 1", wb_valid1);
    end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({wb_valid1, wb_valid2, wb_dest1, wb_data1} !== 39'd0) begin
      errors++; $display("FAIL mid_clear: v1=%b v2=%b d1=%0d w1=%h want 0 0 0 0",
                         wb_valid1, wb_valid2, wb_dest1, wb_data1);
    end
    checks++;
    if ({c2_ready, c1_ready, c0_ready, dut.rr_ptr} !== 5'b000_00) begin
      errors++; $display("FAIL mid_ready_ptr: ready=%b ptr=%0d want 000 0",
                         {c2_ready, c1_ready, c0_ready}, dut.rr_ptr);
    end
    step();
    rst_n = 1;
    #1;
    checks++;
    if ({c2_ready, c1_ready, c0_ready} !== 3'b011) begin
      errors++; $display("FAIL post_ready: got %b want 011", {c2_ready, c1_ready, c0_ready});
    end
    step();
    clear_inputs();
    checks++;
    if ({wb_valid1, wb_dest1, wb_valid2, wb_dest2} !== {1'b1, 5'd1, 1'b1, 5'd2}) begin
      errors++; $display("FAIL post_wb: v1=%b d1=%0d v2=%b d2=%0d want 1 1 1 2",
                         wb_valid1, wb_dest1, wb_valid2, wb_dest2);
    end
    step();
  endtask

  task automatic test_sustained();
    int grants [3];
    int waits [3];
    int max_wait;
    int total;
    int wb_count;
    logic [2:0] rdy;
    grants = '{0, 0, 0};
    waits = '{0, 0, 0};
    max_wait = 0;
    total = 0;
    wb_count = 0;
    c0_valid = 1; c0_dest = 5'd10; c0_data = 32'h100;
    c1_valid = 1; c1_dest = 5'd11; c1_data = 32'h101;
    c2_valid = 1; c2_dest = 5'd13; c2_data = 32'h102;
    for (int cyc = 0; cyc < 30; cyc++) begin
      #1;
      rdy = {c2_ready, c1_ready, c0_ready};
      for (int s = 0; s < 3; s++) begin
        if (rdy[s]) begin
          grants[s]++;
          total++;
          waits[s] = 0;
        end else begin
          waits[s]++;
          if (waits[s] > max_wait) max_wait = waits[s];
        end
      end
      step();
      wb_count += int'(wb_valid1) + int'(wb_valid2);
    end
    clear_inputs();
    checks++;
    if (total !== 60) begin
      errors++; $display("FAIL sustain_total: got %0d want 60", total);
    end
    checks++;
    if (wb_count !== 60) begin
      errors++; $display("FAIL sustain_wb: got %0d want 60", wb_count);
    end
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (grants[s] !== 20) begin
        errors++; $display("FAIL sustain_src%0d: got %0d want 20", s, grants[s]);
      end
    end
    checks++;
    if (max_wait > 1) begin
      errors++; $display("FAIL sustain_wait: got %0d want <=1", max_wait);
    end
    step();
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    #1;
    test_reset();
    test_single();
    test_contention();
    test_zero_dest();
    test_same_dest();
    test_reset_mid();
    test_sustained();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
